// File: rtl/busca_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INSTR_BYTES      : size of one instruction, used as the fetch stride
//   entrada_busca_t  : one fetch-buffer entry, {pc, instr}
//   alinha()         : clears bits [1:0] of an address
package busca_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entrada_busca_t;

    function automatic logic [31:0] alinha(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fila_busca.sv
// Fetch buffer: synchronous FIFO of {pc, instr} entries.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   push, push_data: write one entry (ignored when full and not popping)
//   pop            : remove the head entry (ignored when empty)
//   flush          : empty the buffer; wins over push
//   count          : number of valid entries
//   head           : entry at the head (meaningful only when count != 0)
// DEPTH must be a power of two and at least 2 so the pointers wrap freely.
module fila_busca
    import busca_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           push,
    input  entrada_busca_t push_data,
    input  logic           pop,
    input  logic           flush,
    output logic [CW-1:0]  count,
    output entrada_busca_t head
);

    entrada_busca_t mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop & (count != '0);
    // A full buffer may still accept a write when the head leaves in the same cycle.
    assign do_push = push & ~flush & ((count != CW'(DEPTH)) | do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is never used while count is zero.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch unit: drives fetch addresses into a synchronous instruction
// memory, captures the response one cycle later and hands {pc, instr} pairs to
// decode over a valid/ready handshake.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   counter        : fetch address presented to the instruction memory
//   instrucao_mem  : memory response, valid the cycle after counter
//   instr_valid    : buffer head holds an instruction
//   instr_ready    : decode takes the head this cycle
//   instr_out      : instruction at the head (0 when not valid)
//   pc_out         : address of instr_out (0 when not valid)
//   redirect_valid : branch/jump taken: flush the buffer and refetch
//   redirect_addr  : new fetch address, bits [1:0] ignored
// Handshake: a transfer happens in every cycle where instr_valid and
// instr_ready are both high; while instr_valid is high and instr_ready is low
// the head (instr_out, pc_out) is held stable.
module busca_instrucao
    import busca_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] counter,
    input  logic [31:0] instrucao_mem,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr
);

    localparam int          CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

    logic           inflight;
    logic [31:0]    inflight_pc;
    logic           kill;
    logic [CW-1:0]  count;
    entrada_busca_t head;
    entrada_busca_t push_data;
    logic           pop;
    logic           push;
    logic           issue;
    logic [CW:0]    occupied;
    logic [CW:0]    avail;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    assign push        = inflight & ~kill;
    assign push_data   = {inflight_pc, instrucao_mem};

    // Issue only if the response is guaranteed a slot when it arrives:
    // entries held plus the one in flight must stay below depth plus this
    // cycle's pop. Comparing the two sums avoids a signed subtraction.
    assign occupied = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign avail    = DEPTH_W + {{CW{1'b0}}, pop};
    assign issue    = (avail > occupied) & ~redirect_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter     <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
        end else begin
            inflight <= issue;
            // Any response landing in the cycle after a redirect belongs to
            // the old path; issue is already blocked during redirect, so this
            // is a guard that keeps stale data out regardless.
            kill     <= redirect_valid;
            if (issue) inflight_pc <= counter;
            if (redirect_valid)
                counter <= alinha(redirect_addr);
            else if (issue)
                counter <= counter + INSTR_BYTES;
        end
    end

    fila_busca #(
        .DEPTH (BUF_DEPTH)
    ) u_fila (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign instr_out = instr_valid ? head.instr : '0;
    assign pc_out    = instr_valid ? head.pc    : '0;

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;

  // main DUT (RESET_PC = 0)
  logic [31:0] counter;
  logic [31:0] mem_a;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect_valid;
  logic [31:0] redirect_addr;

  // wrap DUT (RESET_PC = FFFFFFF8), always ready, never redirected
  logic [31:0] counter_w;
  logic [31:0] mem_w;
  logic        valid_w;
  logic        ready_w = 1'b1;
  logic [31:0] instr_out_w;
  logic [31:0] pc_out_w;
  logic        redir_w = 1'b0;
  logic [31:0] redir_addr_w = 32'h0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  busca_instrucao #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .counter        (counter),
    .instrucao_mem  (mem_a),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr)
  );

  busca_instrucao #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
    .clock          (clock),
    .reset_n        (reset_n),
    .counter        (counter_w),
    .instrucao_mem  (mem_w),
    .instr_valid    (valid_w),
    .instr_ready    (ready_w),
    .instr_out      (instr_out_w),
    .pc_out         (pc_out_w),
    .redirect_valid (redir_w),
    .redirect_addr  (redir_addr_w)
  );

  // synchronous instruction memory model: mem[a>>2] = A0000000 | a
  always @(posedge clock) begin
    mem_a <= 32'hA000_0000 | counter;
    mem_w <= 32'hA000_0000 | counter_w;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // reference model: program order from a start address, 4 bytes apart
  task automatic start_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 600; i++) exp_q.push_back(start + 32'(i) * 32'd4);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'b0, instr_valid}, 32'd1);
        check("stall_pc", pc_out, prev_pc);
        check("stall_instr", instr_out, prev_instr);
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_empty at %0t: got pc %h expected nothing", $time, pc_out);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("sb_pc", pc_out, e);
          check("sb_instr", instr_out, 32'hA000_0000 | e);
        end
      end
      prev_stall = instr_valid && !instr_ready && !redirect_valid;
      prev_pc    = pc_out;
      prev_instr = instr_out;
    end
  end

  // ---------------- driver tasks ----------------
  // Called in the cycle reset is released (cycle 0); ends at negedge of cycle n-1.
  task automatic start_checks(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] kk;
      kk = 32'(k);
      @(negedge clock);
      check("start_counter", counter, kk * 32'd4);
      check("start_valid", {31'b0, instr_valid}, (k >= 2) ? 32'd1 : 32'd0);
      check("wrap_counter", counter_w, 32'hFFFF_FFF8 + kk * 32'd4);
      if (k >= 2) begin
        check("start_pc", pc_out, (kk - 32'd2) * 32'd4);
        check("wrap_pc", pc_out_w, 32'hFFFF_FFF8 + (kk - 32'd2) * 32'd4);
        check("wrap_instr", instr_out_w, 32'hA000_0000 | (32'hFFFF_FFF8 + (kk - 32'd2) * 32'd4));
      end
      if (k < n - 1) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  // Entered at the start of redirect cycle r; ends at negedge of r+3.
  task automatic redirect(input logic [31:0] addr, input int ncyc);
    logic [31:0] al;
    al = {addr[31:2], 2'b00};
    redirect_valid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      redirect_addr = (i == ncyc - 1) ? addr : $urandom;
      @(posedge clock);
      #1;
    end
    redirect_valid = 1'b0;
    start_stream(al);
    @(negedge clock);
    check("rd_counter", counter, al);
    check("rd_valid_r1", {31'b0, instr_valid}, 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rd_valid_r2", {31'b0, instr_valid}, 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rd_valid_r3", {31'b0, instr_valid}, 32'd1);
    check("rd_pc_r3", pc_out, al);
    check("rd_instr_r3", instr_out, 32'hA000_0000 | al);
  endtask

  task automatic reset_pulse();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    start_stream(32'h0);
    #1;
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_counter", counter, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_wrap_counter", counter_w, 32'hFFFF_FFF8);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    start_stream(32'h0);
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", {31'b0, instr_valid}, 32'd0);
    check("reset_counter", counter, 32'h0);
    reset_n = 1'b1;

    // test 1 + wrap: back-to-back fetch from reset
    start_checks(4);

    // test 2: stall for 5 cycles with pc 8 at the head
    @(posedge clock);
    #1;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_head_pc", pc_out, 32'h8);
      check("stall_counter", counter, 32'h10);
      check("stall_count", 32'(u_dut.count), (i == 0) ? 32'd1 : 32'd2);
      if (i == 0) check("wrap_pc_zero", pc_out_w, 32'h0);
      @(posedge clock);
      #1;
    end
    instr_ready = 1'b1;
    @(negedge clock);
    check("release_pc8", pc_out, 32'h8);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("release_pcc", pc_out, 32'hC);

    // test 3: redirect to 0x103 while pc 10 is at the head
    @(posedge clock);
    #1;
    check("pre_redirect_pc10", pc_out, 32'h10);
    redirect(32'h0000_0103, 1);

    // test 6: asynchronous reset mid-stream, then restart as in test 1
    reset_pulse();
    start_checks(6);

    // test 5: redirect in the same cycle as pop of pc 4
    reset_pulse();
    start_checks(3);
    @(posedge clock);
    #1;
    check("pre_redirect_pc4", pc_out, 32'h4);
    redirect(32'h0000_2000, 1);

    // randomized phase: random ready, occasional (possibly back-to-back) redirects
    repeat (300) begin
      @(posedge clock);
      #1;
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) redirect($urandom, $urandom_range(1, 2));
    end

    // drain
    @(posedge clock);
    #1;
    instr_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
